// File: rtl/cachepool_boot_ctrl_if.sv
// Reqrsp request/response bundle between the boot controller and the
// cluster peripheral port. The master side issues single 32-bit writes.
interface cachepool_boot_ctrl_if #(
  parameter int unsigned AddrWidth = 48
) ();

  logic [AddrWidth-1:0] q_addr;
  logic [31:0]          q_data;
  logic                 q_write;
  logic [3:0]           q_strb;
  logic                 q_valid;
  logic                 q_ready;
  logic                 p_valid;
  logic                 p_error;
  logic                 p_ready;

  modport master (
    output q_addr, q_data, q_write, q_strb, q_valid, p_ready,
    input  q_ready, p_valid, p_error
  );

  modport slave (
    input  q_addr, q_data, q_write, q_strb, q_valid, p_ready,
    output q_ready, p_valid, p_error
  );

endinterface

// File: rtl/cachepool_boot_ctrl.sv
// Cachepool boot controller: on start, waits WaitCycles, writes the boot
// entry point to the cluster boot register over reqrsp, wakes all cores via
// a one-cycle debug request, then waits for end-of-computation.
// Optional feature macro: CACHEPOOL_BOOT_TIMEOUT_EN adds a RUN-phase
// timeout that ends the sequence in ERR with timeout_o set.
// All outputs are registered and decoded from the next state, so they
// always match the current state one-to-one.
module cachepool_boot_ctrl #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          NumCores      = 4,
  parameter logic [AddrWidth-1:0] BootRegAddr   = '0,
  parameter int unsigned          WaitCycles    = 1000,
  parameter int unsigned          TimeoutCycles = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          entry_point_i,
  input  logic                 eoc_i,
  output logic [AddrWidth-1:0] q_addr_o,
  output logic [31:0]          q_data_o,
  output logic                 q_write_o,
  output logic [3:0]           q_strb_o,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  input  logic                 p_valid_i,
  input  logic                 p_error_i,
  output logic                 p_ready_o,
  output logic [NumCores-1:0]  debug_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 timeout_o
);

  localparam int unsigned CntWidth = 32;
  localparam logic [CntWidth-1:0] WaitLast    = CntWidth'(WaitCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

`ifdef CACHEPOOL_BOOT_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_RSP  = 3'd3,
    S_WAKE = 3'd4,
    S_RUN  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         entry_q, entry_d;

  logic [AddrWidth-1:0] q_addr_q, q_addr_d;
  logic [31:0]          q_data_q, q_data_d;
  logic                 q_write_q, q_write_d;
  logic [3:0]           q_strb_q, q_strb_d;
  logic                 q_valid_q, q_valid_d;
  logic                 p_ready_q, p_ready_d;
  logic [NumCores-1:0]  debug_req_q, debug_req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;

  // State, counter, latched entry point and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      entry_q     <= '0;
      q_addr_q    <= '0;
      q_data_q    <= '0;
      q_write_q   <= 1'b0;
      q_strb_q    <= '0;
      q_valid_q   <= 1'b0;
      p_ready_q   <= 1'b0;
      debug_req_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      q_addr_q    <= q_addr_d;
      q_data_q    <= q_data_d;
      q_write_q   <= q_write_d;
      q_strb_q    <= q_strb_d;
      q_valid_q   <= q_valid_d;
      p_ready_q   <= p_ready_d;
      debug_req_q <= debug_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state, cycle counter and entry-point latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          entry_d = entry_point_i;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CntWidth'(1);
        if ((WaitCycles == 0) || (cnt_q == WaitLast)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // q_valid_o is high for exactly the REQ state, so ready alone
        // completes the handshake here.
        if (q_ready_i) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (p_valid_i) begin
          state_d = p_error_i ? S_ERR : S_WAKE;
        end
      end
      S_WAKE: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // eoc wins over a timeout expiring in the same cycle.
        if (eoc_i) begin
          state_d = S_DONE;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntWidth'(1);
          if ((TimeoutCycles == 0) || (cnt_q == TimeoutLast)) begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    q_addr_d    = '0;
    q_data_d    = '0;
    q_write_d   = 1'b0;
    q_strb_d    = '0;
    q_valid_d   = 1'b0;
    p_ready_d   = 1'b0;
    debug_req_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_d)
      S_WAIT: busy_d = 1'b1;
      S_REQ: begin
        busy_d    = 1'b1;
        q_valid_d = 1'b1;
        q_write_d = 1'b1;
        q_strb_d  = 4'hF;
        q_addr_d  = BootRegAddr;
        q_data_d  = entry_d;
      end
      S_RSP: begin
        busy_d    = 1'b1;
        p_ready_d = 1'b1;
      end
      S_WAKE: begin
        busy_d      = 1'b1;
        debug_req_d = '1;
      end
      S_RUN:  busy_d = 1'b1;
      S_DONE: done_d = 1'b1;
      S_ERR: begin
        error_d = 1'b1;
`ifdef CACHEPOOL_BOOT_TIMEOUT_EN
        // Entering ERR from RUN can only be a timeout; hold it while in ERR.
        timeout_d = (state_q == S_RUN) || timeout_q;
`else
        timeout_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign q_addr_o    = q_addr_q;
  assign q_data_o    = q_data_q;
  assign q_write_o   = q_write_q;
  assign q_strb_o    = q_strb_q;
  assign q_valid_o   = q_valid_q;
  assign p_ready_o   = p_ready_q;
  assign debug_req_o = debug_req_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cachepool_boot_ctrl.sv
// Directed self-checking bench for cachepool_boot_ctrl (WaitCycles=10,
// TimeoutCycles=50). Timeout behaviour is checked per CACHEPOOL_BOOT_TIMEOUT_EN.
module tb_cachepool_boot_ctrl;

  localparam int unsigned AW = 48;
  localparam int unsigned NC = 4;
  localparam logic [AW-1:0] BOOT_ADDR = 48'h0000_1000_0040;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [31:0] entry;
  logic eoc;
  logic [NC-1:0] debug_req;
  logic busy, done, error, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int dbg_cycles = 0;

  cachepool_boot_ctrl_if #(.AddrWidth(AW)) bus ();

  cachepool_boot_ctrl #(
    .AddrWidth(AW), .NumCores(NC), .BootRegAddr(BOOT_ADDR),
    .WaitCycles(10), .TimeoutCycles(50)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .entry_point_i(entry),
    .eoc_i(eoc),
    .q_addr_o(bus.q_addr), .q_data_o(bus.q_data), .q_write_o(bus.q_write),
    .q_strb_o(bus.q_strb), .q_valid_o(bus.q_valid), .q_ready_i(bus.q_ready),
    .p_valid_i(bus.p_valid), .p_error_i(bus.p_error), .p_ready_o(bus.p_ready),
    .debug_req_o(debug_req), .busy_o(busy), .done_o(done), .error_o(error),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Count cycles with any debug request asserted.
  always @(negedge clk) if (debug_req != '0) dbg_cycles++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".addr"},  64'(bus.q_addr), 64'h0);
    check({tag, ".data"},  64'(bus.q_data), 64'h0);
    check({tag, ".flags"}, 64'({bus.q_write, bus.q_strb, bus.q_valid, bus.p_ready}), 64'h0);
    check({tag, ".dbg"},   64'(debug_req), 64'h0);
    check({tag, ".stat"},  64'({busy, done, error, timeout}), 64'h0);
  endtask

  // Start from an idle/final state with q_ready=1 and advance into RUN.
  task automatic go_to_run(input logic [31:0] ep);
    bus.q_ready = 1'b1;
    start = 1'b1; entry = ep;
    tick();
    start = 1'b0; entry = '0;
    repeat (10) tick();          // now REQ
    tick();                      // now RSP
    bus.p_valid = 1'b1; bus.p_error = 1'b0;
    tick();                      // now WAKE
    bus.p_valid = 1'b0;
    tick();                      // now RUN
  endtask

  int dbg_base;

  initial begin
    rst_n = 1'b0; start = 1'b0; entry = '0; eoc = 1'b0;
    bus.q_ready = 1'b0; bus.p_valid = 1'b0; bus.p_error = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", 64'(busy), 64'h0);

    // Nominal boot: write appears 10 cycles after start.
    bus.q_ready = 1'b1;
    start = 1'b1; entry = 32'h8000_3000;
    tick();
    start = 1'b0; entry = '0;
    check("wait_busy", 64'(busy), 64'h1);
    repeat (9) tick();
    check("wait_last_valid", 64'(bus.q_valid), 64'h0);
    tick();
    check("req_valid", 64'(bus.q_valid), 64'h1);
    check("req_data",  64'(bus.q_data), 64'h8000_3000);
    check("req_addr",  64'(bus.q_addr), 64'(BOOT_ADDR));
    check("req_wr_strb", 64'({bus.q_write, bus.q_strb}), 64'h1F);
    check("req_pready", 64'(bus.p_ready), 64'h0);
    dbg_base = dbg_cycles;
    tick();
    check("rsp_valid", 64'(bus.q_valid), 64'h0);
    check("rsp_pready", 64'(bus.p_ready), 64'h1);
    bus.p_valid = 1'b1;
    tick();
    bus.p_valid = 1'b0;
    check("wake_dbg", 64'(debug_req), 64'hF);
    tick();
    check("run_dbg", 64'(debug_req), 64'h0);
    check("run_busy", 64'(busy), 64'h1);
    check("dbg_one_cycle", 64'(dbg_cycles - dbg_base), 64'h1);
    // start during RUN is ignored: eoc must still finish the run.
    start = 1'b1; entry = 32'h0000_1234;
    tick();
    start = 1'b0; entry = '0;
    repeat (3) tick();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("done", 64'({busy, done, error}), 64'b010);

    // Restart from DONE with stalled ready, then error response.
    bus.q_ready = 1'b0;
    start = 1'b1; entry = 32'h8000_0000;
    tick();
    start = 1'b0; entry = '0;
    check("restart_busy", 64'({busy, done}), 64'b10);
    repeat (10) tick();
    check("stall_valid0", 64'(bus.q_valid), 64'h1);
    check("stall_data0",  64'(bus.q_data), 64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(bus.q_valid), 64'h1);
      check("stall_addr",  64'(bus.q_addr), 64'(BOOT_ADDR));
      check("stall_data",  64'(bus.q_data), 64'h8000_0000);
    end
    bus.q_ready = 1'b1;
    dbg_base = dbg_cycles;
    tick();
    bus.q_ready = 1'b0;
    check("rsp2_pready", 64'(bus.p_ready), 64'h1);
    bus.p_valid = 1'b1; bus.p_error = 1'b1;
    tick();
    bus.p_valid = 1'b0; bus.p_error = 1'b0;
    check("err_stat", 64'({busy, done, error, timeout}), 64'b0010);
    tick();
    check("err_no_dbg", 64'(dbg_cycles - dbg_base), 64'h0);

    // Reset asserted mid-handshake in RSP.
    bus.q_ready = 1'b1;
    start = 1'b1; entry = 32'h8000_4000;
    tick();
    start = 1'b0; entry = '0;
    repeat (10) tick();
    tick();
    check("rsp3_pready", 64'(bus.p_ready), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_rsp");
    @(negedge clk) rst_n = 1'b1;
    repeat (15) tick();
    check("no_reissue", 64'({bus.q_valid, busy}), 64'h0);

    // RUN-phase timeout handling.
    go_to_run(32'h8000_5000);
    repeat (49) tick();
    check("run49_stat", 64'({busy, error}), 64'b10);
`ifdef CACHEPOOL_BOOT_TIMEOUT_EN
    tick();
    check("timeout_stat", 64'({busy, done, error, timeout}), 64'b0011);
    go_to_run(32'h8000_6000);
    check("timeout_clr", 64'(timeout), 64'h0);
    repeat (49) tick();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("eoc_wins", 64'({busy, done, error, timeout}), 64'b0100);
`else
    repeat (100) tick();
    check("no_timeout", 64'({busy, done, error, timeout}), 64'b1000);
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("late_eoc", 64'({busy, done, error, timeout}), 64'b0100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
